// File: rtl/waypoint_sequencer.sv
// Waypoint mission sequencer. It compares each decoded GPS fix with the active target in a small
// table, drives the steering and proximity flags, counts arrivals and watches for fix timeouts.
module waypoint_sequencer #(
    parameter int          NUM_WP       = 4,
    parameter int          ARRIVE_CNT   = 3,
    parameter int          STALE_CYCLES = 1000000,
    parameter logic [19:0] ACCURACY     = 20'h0000A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fix_valid,
    input  logic [7:0]  latd,
    input  logic [7:0]  lond,
    input  logic [19:0] latm,
    input  logic [19:0] lonm,
    input  logic        wp_wr_en,
    input  logic [1:0]  wp_wr_addr,
    input  logic [27:0] wp_wr_lat,
    input  logic [27:0] wp_wr_lon,
    input  logic [1:0]  wp_last,
    input  logic        start,
    input  logic        abort,
    output logic        go_north,
    output logic        go_east,
    output logic        lat_prox,
    output logic        lon_prox,
    output logic        drive_en,
    output logic [1:0]  wp_idx,
    output logic        arrived,
    output logic        mission_done,
    output logic        stale
);

    localparam int CNT_W = (ARRIVE_CNT > 1) ? $clog2(ARRIVE_CNT + 1) : 1;
    localparam int TMR_W = $clog2(STALE_CYCLES + 1);
    localparam logic [CNT_W-1:0] ARRIVE_LAST = CNT_W'(ARRIVE_CNT - 1);
    localparam logic [TMR_W-1:0] STALE_LAST  = TMR_W'(STALE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_NAV     = 3'd1,
        ST_ADVANCE = 3'd2,
        ST_STALE   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Absolute minutes distance from a 21-bit subtraction, so small targets never wrap.
    function automatic logic [20:0] min_dist(input logic [19:0] a, input logic [19:0] b);
        logic [20:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[20]) begin
            min_dist = (~d) + 21'd1;
        end else begin
            min_dist = d;
        end
    endfunction

    state_t            state_r;
    logic [27:0]       lat_tbl_r [NUM_WP];
    logic [27:0]       lon_tbl_r [NUM_WP];
    logic [7:0]        fix_latd_r;
    logic [7:0]        fix_lond_r;
    logic [19:0]       fix_latm_r;
    logic [19:0]       fix_lonm_r;
    logic              eval_pend_r;
    logic [CNT_W-1:0]  arr_cnt_r;
    logic [TMR_W-1:0]  tmr_r;
    logic [1:0]        wp_idx_r;
    logic [1:0]        wp_last_r;
    logic              go_north_r;
    logic              go_east_r;
    logic              lat_prox_r;
    logic              lon_prox_r;
    logic              drive_en_r;
    logic              arrived_r;
    logic              mission_done_r;
    logic              stale_r;

    logic [27:0]       tgt_lat_s;
    logic [27:0]       tgt_lon_s;
    logic              north_s;
    logic              east_s;
    logic              lat_prox_s;
    logic              lon_prox_s;
    logic              both_prox_s;
    logic              eval_s;
    logic              arrive_s;
    logic              expire_s;
    logic [CNT_W-1:0]  cnt_next_s;

    // Waypoint table: writable only while the mission is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WP; i++) begin
                lat_tbl_r[i] <= 28'd0;
                lon_tbl_r[i] <= 28'd0;
            end
        end else if (wp_wr_en && (state_r == ST_IDLE)) begin
            lat_tbl_r[wp_wr_addr] <= wp_wr_lat;
            lon_tbl_r[wp_wr_addr] <= wp_wr_lon;
        end
    end

    // Fix capture stage; the eval stage decides whether the captured fix is used
    always_ff @(posedge clk) begin
        if (rst) begin
            fix_latd_r <= 8'd0;
            fix_lond_r <= 8'd0;
            fix_latm_r <= 20'd0;
            fix_lonm_r <= 20'd0;
        end else if (fix_valid) begin
            fix_latd_r <= latd;
            fix_lond_r <= lond;
            fix_latm_r <= latm;
            fix_lonm_r <= lonm;
        end
    end

    // Compare the captured fix against the active target
    always_comb begin
        tgt_lat_s   = lat_tbl_r[wp_idx_r];
        tgt_lon_s   = lon_tbl_r[wp_idx_r];
        north_s     = ({fix_latd_r, fix_latm_r} < tgt_lat_s);
        east_s      = ({fix_lond_r, fix_lonm_r} < tgt_lon_s);
        lat_prox_s  = (fix_latd_r == tgt_lat_s[27:20]) &&
                      (min_dist(fix_latm_r, tgt_lat_s[19:0]) <= {1'b0, ACCURACY});
        lon_prox_s  = (fix_lond_r == tgt_lon_s[27:20]) &&
                      (min_dist(fix_lonm_r, tgt_lon_s[19:0]) <= {1'b0, ACCURACY});
        both_prox_s = lat_prox_s && lon_prox_s;
        eval_s      = eval_pend_r && ((state_r == ST_NAV) || (state_r == ST_STALE));
        arrive_s    = eval_pend_r && (state_r == ST_NAV) && both_prox_s && (arr_cnt_r == ARRIVE_LAST);
        expire_s    = !fix_valid && (tmr_r == STALE_LAST);
        if (both_prox_s) begin
            cnt_next_s = arr_cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_next_s = {CNT_W{1'b0}};
        end
    end

    // Mission FSM with registered steering outputs, arrival counter and fix-timeout timer
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_r        <= ST_IDLE;
            eval_pend_r    <= 1'b0;
            arr_cnt_r      <= {CNT_W{1'b0}};
            tmr_r          <= {TMR_W{1'b0}};
            wp_idx_r       <= 2'd0;
            wp_last_r      <= 2'd0;
            go_north_r     <= 1'b0;
            go_east_r      <= 1'b0;
            lat_prox_r     <= 1'b0;
            lon_prox_r     <= 1'b0;
            drive_en_r     <= 1'b0;
            arrived_r      <= 1'b0;
            mission_done_r <= 1'b0;
            stale_r        <= 1'b0;
        end else begin
            eval_pend_r <= fix_valid && ((state_r == ST_NAV) || (state_r == ST_STALE));
            if (eval_s) begin
                go_north_r <= north_s;
                go_east_r  <= east_s;
                lat_prox_r <= lat_prox_s;
                lon_prox_r <= lon_prox_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r        <= ST_NAV;
                        wp_idx_r       <= 2'd0;
                        wp_last_r      <= wp_last;
                        arr_cnt_r      <= {CNT_W{1'b0}};
                        tmr_r          <= {TMR_W{1'b0}};
                        drive_en_r     <= 1'b0;
                        mission_done_r <= 1'b0;
                    end
                end
                ST_NAV: begin
                    if (arrive_s) begin
                        state_r    <= ST_ADVANCE;
                        arrived_r  <= 1'b1;
                        drive_en_r <= 1'b0;
                        arr_cnt_r  <= {CNT_W{1'b0}};
                    end else if (expire_s) begin
                        state_r    <= ST_STALE;
                        stale_r    <= 1'b1;
                        drive_en_r <= 1'b0;
                        arr_cnt_r  <= {CNT_W{1'b0}};
                        tmr_r      <= {TMR_W{1'b0}};
                    end else begin
                        if (eval_pend_r) begin
                            arr_cnt_r  <= cnt_next_s;
                            drive_en_r <= 1'b1;
                        end
                        if (fix_valid) begin
                            tmr_r <= {TMR_W{1'b0}};
                        end else begin
                            tmr_r <= tmr_r + TMR_W'(1'b1);
                        end
                    end
                end
                ST_ADVANCE: begin
                    arrived_r <= 1'b0;
                    arr_cnt_r <= {CNT_W{1'b0}};
                    if (wp_idx_r == wp_last_r) begin
                        state_r        <= ST_DONE;
                        mission_done_r <= 1'b1;
                    end else begin
                        state_r  <= ST_NAV;
                        wp_idx_r <= wp_idx_r + 2'd1;
                        tmr_r    <= {TMR_W{1'b0}};
                    end
                end
                ST_STALE: begin
                    if (fix_valid) begin
                        state_r <= ST_NAV;
                        stale_r <= 1'b0;
                        tmr_r   <= {TMR_W{1'b0}};
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign go_north     = go_north_r;
    assign go_east      = go_east_r;
    assign lat_prox     = lat_prox_r;
    assign lon_prox     = lon_prox_r;
    assign drive_en     = drive_en_r;
    assign wp_idx       = wp_idx_r;
    assign arrived      = arrived_r;
    assign mission_done = mission_done_r;
    assign stale        = stale_r;

endmodule

// File: tb/tb_waypoint_sequencer.sv
// Directed bench for waypoint_sequencer: steering, proximity bounds, arrival counting,
// mission completion, fix timeout and abort, all against hand-computed expectations.
module tb_waypoint_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fix_valid;
    logic [7:0]  latd;
    logic [7:0]  lond;
    logic [19:0] latm;
    logic [19:0] lonm;
    logic        wp_wr_en;
    logic [1:0]  wp_wr_addr;
    logic [27:0] wp_wr_lat;
    logic [27:0] wp_wr_lon;
    logic [1:0]  wp_last;
    logic        start;
    logic        abort;
    logic        go_north;
    logic        go_east;
    logic        lat_prox;
    logic        lon_prox;
    logic        drive_en;
    logic [1:0]  wp_idx;
    logic        arrived;
    logic        mission_done;
    logic        stale;

    int checks   = 0;
    int failures = 0;

    logic [19:0] pb_latm [5];
    logic [7:0]  pb_latd [5];
    logic [7:0]  pb_exp  [5];
    logic        ar_in   [6];

    waypoint_sequencer #(
        .NUM_WP(4), .ARRIVE_CNT(3), .STALE_CYCLES(100), .ACCURACY(20'h0000A)
    ) dut (
        .clk(clk), .rst(rst), .fix_valid(fix_valid),
        .latd(latd), .lond(lond), .latm(latm), .lonm(lonm),
        .wp_wr_en(wp_wr_en), .wp_wr_addr(wp_wr_addr), .wp_wr_lat(wp_wr_lat), .wp_wr_lon(wp_wr_lon),
        .wp_last(wp_last), .start(start), .abort(abort),
        .go_north(go_north), .go_east(go_east), .lat_prox(lat_prox), .lon_prox(lon_prox),
        .drive_en(drive_en), .wp_idx(wp_idx), .arrived(arrived),
        .mission_done(mission_done), .stale(stale)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs packed as {N, E, LP, OP, DRV, ARR, DONE, STALE}
    task automatic check_outs(input string tag, input logic [7:0] exp_o, input logic [1:0] exp_idx);
        logic [7:0] obs;
        obs = {go_north, go_east, lat_prox, lon_prox, drive_en, arrived, mission_done, stale};
        checks++;
        assert (obs === exp_o && wp_idx === exp_idx) else begin
            failures++;
            $error("FAIL %s: observed outs=%b idx=%0d expected outs=%b idx=%0d",
                   tag, obs, wp_idx, exp_o, exp_idx);
        end
    endtask

    task automatic send_fix(input logic [7:0] ld, input logic [19:0] lm,
                            input logic [7:0] od, input logic [19:0] om);
        latd = ld; latm = lm; lond = od; lonm = om;
        fix_valid = 1'b1;
        step();
        fix_valid = 1'b0;
    endtask

    task automatic fix_eval(input logic [7:0] ld, input logic [19:0] lm,
                            input logic [7:0] od, input logic [19:0] om);
        send_fix(ld, lm, od, om);
        step();
    endtask

    task automatic write_wp(input logic [1:0] a, input logic [27:0] la, input logic [27:0] lo);
        wp_wr_en = 1'b1; wp_wr_addr = a; wp_wr_lat = la; wp_wr_lon = lo;
        step();
        wp_wr_en = 1'b0;
    endtask

    task automatic start_mission(input logic [1:0] last);
        start = 1'b1; wp_last = last;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fix_valid = 1'b0; latd = 8'h00; lond = 8'h00; latm = 20'h0; lonm = 20'h0;
        wp_wr_en = 1'b0; wp_wr_addr = 2'd0; wp_wr_lat = 28'h0; wp_wr_lon = 28'h0;
        wp_last = 2'd0; start = 1'b0; abort = 1'b0;
        step(); step();
        check_outs("reset_state", 8'b0000_0000, 2'd0);
        rst = 1'b0;

        // reset in the middle of navigation clears outputs and table
        write_wp(2'd0, {8'h2C, 20'h84153}, {8'h44, 20'h61D60});
        start_mission(2'd0);
        fix_eval(8'h2C, 20'h84153, 8'h44, 20'h61D60);
        check_outs("pre_reset_eval", 8'b0011_1000, 2'd0);
        rst = 1'b1; step(); step(); rst = 1'b0;
        check_outs("mid_nav_reset", 8'b0000_0000, 2'd0);
        start_mission(2'd0);
        fix_eval(8'h00, 20'h00000, 8'h00, 20'h00000);
        check_outs("table_cleared", 8'b0011_1000, 2'd0);
        abort = 1'b1; step(); abort = 1'b0;
        check_outs("abort_nav", 8'b0000_0000, 2'd0);

        // direction and pipeline latency
        write_wp(2'd0, {8'h2C, 20'h84153}, {8'h44, 20'h61D60});
        write_wp(2'd1, {8'h10, 20'h00100}, {8'h20, 20'h00200});
        start_mission(2'd1);
        check_outs("start_drive_off", 8'b0000_0000, 2'd0);
        send_fix(8'h2C, 20'h84000, 8'h44, 20'h62000);
        check_outs("pipe_n1", 8'b0000_0000, 2'd0);
        step();
        check_outs("direction", 8'b1000_1000, 2'd0);

        // proximity bounds on latitude, longitude held on target
        pb_latd[0] = 8'h2C; pb_latm[0] = 20'h84149; pb_exp[0] = 8'b1011_1000;
        pb_latd[1] = 8'h2C; pb_latm[1] = 20'h8415D; pb_exp[1] = 8'b0011_1000;
        pb_latd[2] = 8'h2C; pb_latm[2] = 20'h84148; pb_exp[2] = 8'b1001_1000;
        pb_latd[3] = 8'h2C; pb_latm[3] = 20'h8415E; pb_exp[3] = 8'b0001_1000;
        pb_latd[4] = 8'h2B; pb_latm[4] = 20'h84153; pb_exp[4] = 8'b1001_1000;
        for (int i = 0; i < 5; i++) begin
            fix_eval(pb_latd[i], pb_latm[i], 8'h44, 20'h61D60);
            check_outs($sformatf("prox_bound_%0d", i), pb_exp[i], 2'd0);
        end

        // arrival needs three consecutive in-proximity fixes
        ar_in[0] = 1'b1; ar_in[1] = 1'b1; ar_in[2] = 1'b0;
        ar_in[3] = 1'b1; ar_in[4] = 1'b1; ar_in[5] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fix_eval(8'h2C, ar_in[i] ? 20'h84153 : 20'h84148, 8'h44, 20'h61D60);
            check_outs($sformatf("arrive_seq_%0d", i), ar_in[i] ? 8'b0011_1000 : 8'b1001_1000, 2'd0);
        end
        fix_eval(8'h2C, 20'h84153, 8'h44, 20'h61D60);
        check_outs("arrived_pulse", 8'b0011_0100, 2'd0);
        step();
        check_outs("advance_wp1", 8'b0011_0000, 2'd1);

        // fix timeout: a fix in the expiry cycle wins, otherwise STALE after 100 cycles
        fix_eval(8'h10, 20'h00100, 8'h20, 20'h00150);
        check_outs("wp1_eval", 8'b0110_1000, 2'd1);
        for (int i = 0; i < 98; i++) step();
        send_fix(8'h10, 20'h00100, 8'h20, 20'h00150);
        check_outs("expiry_fix_wins", 8'b0110_1000, 2'd1);
        step();
        for (int i = 0; i < 98; i++) step();
        check_outs("pre_expiry", 8'b0110_1000, 2'd1);
        step();
        check_outs("stale_enter", 8'b0110_0001, 2'd1);
        send_fix(8'h10, 20'h00100, 8'h20, 20'h00300);
        check_outs("stale_exit", 8'b0110_0000, 2'd1);
        step();
        check_outs("stale_eval", 8'b0010_1000, 2'd1);

        // final waypoint arrival ends the mission
        fix_eval(8'h10, 20'h00100, 8'h20, 20'h00200);
        fix_eval(8'h10, 20'h00100, 8'h20, 20'h00200);
        check_outs("final_in_2", 8'b0011_1000, 2'd1);
        fix_eval(8'h10, 20'h00100, 8'h20, 20'h00200);
        check_outs("final_arrived", 8'b0011_0100, 2'd1);
        step();
        check_outs("mission_done", 8'b0011_0010, 2'd1);
        fix_eval(8'h2C, 20'h84000, 8'h44, 20'h62000);
        check_outs("done_ignores_fix", 8'b0011_0010, 2'd1);

        // abort beats start; table writes only land in IDLE
        start = 1'b1; abort = 1'b1; wp_last = 2'd1;
        step();
        start = 1'b0; abort = 1'b0;
        check_outs("start_abort", 8'b0000_0000, 2'd0);
        write_wp(2'd0, {8'h30, 20'h00050}, {8'h31, 20'h00050});
        start_mission(2'd0);
        write_wp(2'd0, 28'h0000000, 28'h0000000);
        fix_eval(8'h30, 20'h00050, 8'h31, 20'h00050);
        check_outs("nav_write_ignored", 8'b0011_1000, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
